// File: rtl/osc_mon_pkg.sv
// Shared types and defaults for the oscillation window monitor.
package osc_mon_pkg;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    WINDOW = 2'd2,
    ALARM  = 2'd3
  } state_e;

  // Default parameter values.
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_WIN_LEN     = 16;
  localparam int DEF_THRESH      = 4;
  localparam int DEF_CNT_W       = 5;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int win_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osc_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
module osc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      // Each stage samples the previous one; stage 0 samples the raw input.
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!rst_n) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= d_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!rst_n) sync_q[gi] <= 1'b0;
          else        sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/osc_window_monitor.sv
// Counts toggles of a synchronised loop net over fixed windows and raises a
// sticky alarm when a window is too busy or the loop's OscFlag was seen.
module osc_window_monitor
  import osc_mon_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int WIN_LEN     = DEF_WIN_LEN,
  parameter int THRESH      = DEF_THRESH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             sense_i,
  input  logic             osc_flag_i,
  output logic             osc_alarm_o,
  output logic             win_done_o,
  output logic [CNT_W-1:0] last_toggles_o,
  output logic             busy_o
);

  localparam int WIN_W = win_cnt_width(WIN_LEN);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_THR  = THRESH[CNT_W-1:0];
  localparam logic [WIN_W-1:0] WIN_ONE  = 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  logic             s_sense;
  logic             s_flag;

  state_e           state_q;
  logic             prev_q;
  logic [CNT_W-1:0] tog_cnt_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic             flag_seen_q;
  logic             alarm_q;
  logic             win_done_q;
  logic [CNT_W-1:0] last_tog_q;

  logic             toggle;
  logic [CNT_W-1:0] tog_cnt_d;
  logic             flag_seen_d;
  logic             win_last;
  logic             window_hit;

  osc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sense (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sense_i),
    .q_o   (s_sense)
  );

  osc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_flag (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (osc_flag_i),
    .q_o   (s_flag)
  );

  // Per-cycle window arithmetic: toggle detect, saturating count, flag OR.
  always_comb begin
    toggle      = s_sense ^ prev_q;
    tog_cnt_d   = tog_cnt_q;
    if (toggle && (tog_cnt_q != CNT_MAX)) begin
      tog_cnt_d = tog_cnt_q + CNT_ONE;
    end
    flag_seen_d = flag_seen_q | s_flag;
    win_last    = (win_cnt_q == WIN_LAST);
    window_hit  = (tog_cnt_d >= CNT_THR) || flag_seen_d;
  end

  // Monitor FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= 1'b0;
      tog_cnt_q   <= '0;
      win_cnt_q   <= '0;
      flag_seen_q <= 1'b0;
      alarm_q     <= 1'b0;
      win_done_q  <= 1'b0;
      last_tog_q  <= '0;
    end else begin
      // prev tracks the synchronised net every cycle; in ARM this is the
      // baseline, so the first window cycle only sees genuine changes.
      prev_q     <= s_sense;
      win_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          tog_cnt_q   <= '0;
          win_cnt_q   <= '0;
          flag_seen_q <= 1'b0;
          if (en_i) state_q <= ARM;
        end

        ARM: begin
          tog_cnt_q   <= '0;
          win_cnt_q   <= '0;
          flag_seen_q <= 1'b0;
          state_q     <= en_i ? WINDOW : IDLE;
        end

        WINDOW: begin
          if (!en_i) begin
            // Partial window is dropped silently.
            tog_cnt_q   <= '0;
            win_cnt_q   <= '0;
            flag_seen_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tog_cnt_q   <= tog_cnt_d;
            flag_seen_q <= flag_seen_d;
            win_cnt_q   <= win_cnt_q + WIN_ONE;
            if (win_last) begin
              win_done_q <= 1'b1;
              last_tog_q <= tog_cnt_d;
              // A clear arriving on the same edge suppresses the alarm.
              if (window_hit && !clr_i) begin
                alarm_q <= 1'b1;
                state_q <= ALARM;
              end else begin
                state_q <= ARM;
              end
            end
          end
        end

        ALARM: begin
          if (clr_i) begin
            alarm_q <= 1'b0;
            state_q <= en_i ? ARM : IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign osc_alarm_o    = alarm_q;
  assign win_done_o     = win_done_q;
  assign last_toggles_o = last_tog_q;
  assign busy_o         = (state_q == ARM) || (state_q == WINDOW);

endmodule

// File: tb/tb_osc_window_monitor.sv
// Directed bench for osc_window_monitor: default instance plus a long-window
// instance for counter saturation.
module tb_osc_window_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_i, clr_i, sense_i, osc_flag_i;
  logic       osc_alarm_o, win_done_o, busy_o;
  logic [4:0] last_toggles_o;

  logic       en_s, clr_s, sense_s, flag_s;
  logic       alarm_s, win_done_s, busy_s;
  logic [4:0] last_s;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  osc_window_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_i),
    .clr_i          (clr_i),
    .sense_i        (sense_i),
    .osc_flag_i     (osc_flag_i),
    .osc_alarm_o    (osc_alarm_o),
    .win_done_o     (win_done_o),
    .last_toggles_o (last_toggles_o),
    .busy_o         (busy_o)
  );

  osc_window_monitor #(.WIN_LEN(40)) dut_sat (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en_s),
    .clr_i          (clr_s),
    .sense_i        (sense_s),
    .osc_flag_i     (flag_s),
    .osc_alarm_o    (alarm_s),
    .win_done_o     (win_done_s),
    .last_toggles_o (last_s),
    .busy_o         (busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts in an ARM cycle; runs 17 cycles and ends on the win_done cycle.
  // Toggles land on odd offsets, flag is held for nflag cycles from offset 1,
  // and clr_i optionally pulses on the last window cycle.
  task automatic run_window(input int ntog, input int nflag, input bit clr_last);
    for (int k = 0; k < 17; k++) begin
      if ((k % 2 == 1) && (k / 2 < ntog)) sense_i = ~sense_i;
      osc_flag_i = (k >= 1) && (k <= nflag);
      clr_i      = clr_last && (k == 16);
      tick();
      if (k < 16) check("win_done_early", win_done_o, 0);
    end
    osc_flag_i = 1'b0;
    clr_i      = 1'b0;
    $display("[TB] window ntog=%0d nflag=%0d clr=%0d -> last=%0d alarm=%0d",
             ntog, nflag, clr_last, last_toggles_o, osc_alarm_o);
  endtask

  initial begin
    rst_n = 1'b0; en_i = 1'b1; clr_i = 1'b0; sense_i = 1'b0; osc_flag_i = 1'b0;
    en_s = 1'b0; clr_s = 1'b0; sense_s = 1'b0; flag_s = 1'b0;

    // Reset held with enable and toggling input: everything stays at zero.
    tick();
    for (int i = 0; i < 4; i++) begin
      sense_i = ~sense_i;
      tick();
      check("rst_alarm", osc_alarm_o, 0);
      check("rst_done", win_done_o, 0);
      check("rst_last", last_toggles_o, 0);
      check("rst_busy", busy_o, 0);
    end
    sense_i = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("arm_after_reset", busy_o, 1);

    // Quiet windows: done every 17 cycles, zero toggles, no alarm.
    run_window(0, 0, 1'b0);
    check("w1_done", win_done_o, 1);
    check("w1_last", last_toggles_o, 0);
    check("w1_alarm", osc_alarm_o, 0);
    check("w1_busy", busy_o, 1);
    run_window(0, 0, 1'b0);
    check("w2_done", win_done_o, 1);
    check("w2_last", last_toggles_o, 0);

    // Three toggles: below threshold.
    run_window(3, 0, 1'b0);
    check("t3_done", win_done_o, 1);
    check("t3_last", last_toggles_o, 3);
    check("t3_alarm", osc_alarm_o, 0);

    // Enable dropped mid-window: partial window discarded.
    for (int i = 0; i < 5; i++) begin
      sense_i = ~sense_i;
      tick();
    end
    en_i = 1'b0;
    tick();
    check("drop_busy", busy_o, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("drop_no_done", win_done_o, 0);
    end
    check("drop_last_kept", last_toggles_o, 3);
    en_i = 1'b1;
    tick();
    check("rearm_busy", busy_o, 1);

    // Four toggles: at threshold -> alarm, sticky.
    run_window(4, 0, 1'b0);
    check("t4_done", win_done_o, 1);
    check("t4_last", last_toggles_o, 4);
    check("t4_alarm", osc_alarm_o, 1);
    check("t4_busy", busy_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_alarm_held", osc_alarm_o, 1);
      check("t4_no_done", win_done_o, 0);
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_alarm", osc_alarm_o, 0);
    check("clr_to_arm", busy_o, 1);

    // OscFlag pulse with no toggles -> alarm.
    run_window(0, 3, 1'b0);
    check("flag_done", win_done_o, 1);
    check("flag_last", last_toggles_o, 0);
    check("flag_alarm", osc_alarm_o, 1);

    // Enable low in ALARM holds alarm until clear, then IDLE.
    en_i = 1'b0;
    tick();
    check("alarm_en0_held", osc_alarm_o, 1);
    check("alarm_en0_busy", busy_o, 0);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("clr_en0_alarm", osc_alarm_o, 0);
    check("clr_en0_busy", busy_o, 0);
    tick();
    check("idle_stays", busy_o, 0);
    en_i = 1'b1;
    tick();
    check("idle_to_arm", busy_o, 1);

    // Clear coincident with an alarming window end: clear wins.
    run_window(4, 0, 1'b1);
    check("coin_done", win_done_o, 1);
    check("coin_last", last_toggles_o, 4);
    check("coin_alarm", osc_alarm_o, 0);
    check("coin_busy", busy_o, 1);
    tick();
    check("coin_alarm_after", osc_alarm_o, 0);
    check("coin_done_pulse", win_done_o, 0);

    // Saturation: 40-cycle window, toggling every cycle -> count pinned at 31.
    en_s = 1'b1;
    tick();
    check("sat_arm", busy_s, 1);
    for (int k = 0; k < 41; k++) begin
      if (k < 40) sense_s = ~sense_s;
      tick();
      if (k < 40) check("sat_done_early", win_done_s, 0);
    end
    $display("[TB] saturation window -> last=%0d alarm=%0d", last_s, alarm_s);
    check("sat_done", win_done_s, 1);
    check("sat_last", last_s, 31);
    check("sat_alarm", alarm_s, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
